// File: rtl/bitty_fetch_if.sv
// bitty_fetch_if -- signal bundle between the Bitty fetch unit, its
// instruction memory and the Bitty core.
//
// Parameter:
//   ADDR_W        program counter / memory address width
//
// Signals:
//   start, start_addr, end_addr   program run request and bounds
//   mem_rd, mem_addr, mem_data    synchronous instruction memory port
//                                 (data valid the cycle after mem_rd)
//   instr, run, done              core instruction handshake
//   pc, busy, halted, err         sequencer status
//   instr_count, stall_cycles     performance counters, present only when
//                                 BITTY_FETCH_PERF_EN is defined
//
// Modports:
//   master  the fetch unit
//   slave   the environment (memory, core, controller)
interface bitty_fetch_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] end_addr;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_data;
    logic [15:0]       instr;
    logic              run;
    logic              done;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              halted;
    logic              err;
`ifdef BITTY_FETCH_PERF_EN
    logic [15:0]       instr_count;
    logic [15:0]       stall_cycles;
`endif

    modport master (
        input  start, start_addr, end_addr, mem_data, done,
`ifdef BITTY_FETCH_PERF_EN
        output instr_count, stall_cycles,
`endif
        output mem_rd, mem_addr, instr, run, pc, busy, halted, err
    );

    modport slave (
        output start, start_addr, end_addr, mem_data, done,
`ifdef BITTY_FETCH_PERF_EN
        input  instr_count, stall_cycles,
`endif
        input  mem_rd, mem_addr, instr, run, pc, busy, halted, err
    );
endinterface

// File: rtl/bitty_fetch_unit.sv
// bitty_fetch_unit -- instruction sequencer for the Bitty core.
//
// Reads 16-bit instructions from a synchronous instruction memory, hands
// each one to the core with a single-cycle run pulse and waits for done.
// The program counter walks from start_addr to end_addr (modular wrap) and
// the unit halts after the instruction at end_addr has completed. A core
// that does not answer within TIMEOUT cycles sets the sticky err flag and
// halts the run.
//
// Parameters:
//   ADDR_W   program counter / memory address width
//   TIMEOUT  EXEC cycles allowed before err is raised (1 .. 65535)
//
// Ports:
//   clk      system clock, rising edge
//   rst      asynchronous active-high reset
//   bus      bitty_fetch_if.master: start/start_addr/end_addr, memory
//            port, core run/done/instr, pc/busy/halted/err status
//
// Optional feature (macro BITTY_FETCH_PERF_EN):
//   bus.instr_count   done pulses accepted since the last start (saturating)
//   bus.stall_cycles  EXEC cycles since the last start (saturating)
//
// Every output is either a flop or a decode of the state register, so
// done and mem_data never reach an output combinationally.
module bitty_fetch_unit #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    bitty_fetch_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_MEM,
        S_ISSUE,
        S_EXEC,
        S_HALT
    } state_t;

    // The counter holds the number of completed EXEC cycles, so the last
    // allowed EXEC cycle is the one in which it still reads TIMEOUT-1.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] end_q;
    logic [15:0]       instr_q;
    logic [15:0]       tmo_q;
    logic              err_q;

    logic start_acc;
    logic at_end;
    logic tmo_hit;

    assign start_acc = ((state == S_IDLE) || (state == S_HALT)) && bus.start;
    assign at_end    = (pc_q == end_q);
    assign tmo_hit   = (tmo_q == TMO_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_HALT: begin
                if (bus.start) begin
                    state_nx = S_FETCH;
                end
            end
            S_FETCH:    state_nx = S_WAIT_MEM;
            S_WAIT_MEM: state_nx = S_ISSUE;
            S_ISSUE:    state_nx = S_EXEC;
            S_EXEC: begin
                // done takes priority over a timeout landing in the same cycle
                if (bus.done) begin
                    state_nx = at_end ? S_HALT : S_FETCH;
                end else if (tmo_hit) begin
                    state_nx = S_HALT;
                end
            end
            default:    state_nx = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: pc, end bound, instruction latch, timeout counter, err
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= '0;
            end_q   <= '0;
            instr_q <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            if (start_acc) begin
                pc_q  <= bus.start_addr;
                end_q <= bus.end_addr;
                err_q <= 1'b0;
            end

            // Memory data arrives the cycle after the FETCH read strobe.
            if (state == S_WAIT_MEM) begin
                instr_q <= bus.mem_data;
            end

            if (state == S_ISSUE) begin
                tmo_q <= '0;
            end else if (state == S_EXEC) begin
                tmo_q <= tmo_q + 16'd1;
            end

            if (state == S_EXEC) begin
                if (bus.done) begin
                    // pc stays on end_addr at halt; otherwise modular advance
                    if (!at_end) begin
                        pc_q <= pc_q + ADDR_W'(1);
                    end
                end else if (tmo_hit) begin
                    err_q <= 1'b1;
                end
            end
        end
    end

`ifdef BITTY_FETCH_PERF_EN
    // ------------------------------------------------------------------
    // Performance counters, saturating, cleared by an accepted start
    // ------------------------------------------------------------------
    logic [15:0] icnt_q;
    logic [15:0] stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            icnt_q  <= '0;
            stall_q <= '0;
        end else if (start_acc) begin
            icnt_q  <= '0;
            stall_q <= '0;
        end else if (state == S_EXEC) begin
            if (stall_q != 16'hFFFF) begin
                stall_q <= stall_q + 16'd1;
            end
            if (bus.done && (icnt_q != 16'hFFFF)) begin
                icnt_q <= icnt_q + 16'd1;
            end
        end
    end

    assign bus.instr_count  = icnt_q;
    assign bus.stall_cycles = stall_q;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // mem_addr simply follows pc; it is only meaningful while mem_rd is high.
    assign bus.mem_rd   = (state == S_FETCH);
    assign bus.mem_addr = pc_q;
    assign bus.run      = (state == S_ISSUE);
    assign bus.instr    = instr_q;
    assign bus.pc       = pc_q;
    assign bus.busy     = (state == S_FETCH) || (state == S_WAIT_MEM) ||
                          (state == S_ISSUE) || (state == S_EXEC);
    assign bus.halted   = (state == S_HALT);
    assign bus.err      = err_q;

endmodule

// File: tb/tb_bitty_fetch_unit.sv
// tb_bitty_fetch_unit -- directed self-checking bench for bitty_fetch_unit.
// The bench models the synchronous instruction memory and a simple core
// that answers each run with done a configurable number of cycles later.
module tb_bitty_fetch_unit;
    localparam int ADDR_W  = 8;
    localparam int TIMEOUT = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    bitty_fetch_if #(.ADDR_W(ADDR_W)) bus ();

    bitty_fetch_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int start_cyc = 0;

    logic [15:0] mem [0:255];
    bit          pend_rd;
    logic [7:0]  pend_addr;

    logic [15:0] run_q[$];
    int          runcyc_q[$];
    logic [7:0]  fetch_q[$];

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_start(input logic [7:0] sa, input logic [7:0] ea);
        bus.start      = 1'b1;
        bus.start_addr = sa;
        bus.end_addr   = ea;
        start_cyc      = cyc;
    endtask

    // Runs memory + core model until HALT, or until stop_runs runs have been
    // seen and the first EXEC cycle of the last one is reached.
    // delay: core raises done in cycle (run cycle + delay + 1).
    task automatic run_prog(input int delay, input bit stray, input int stop_runs,
                            input int max_cyc);
        int  done_at;
        int  last_run;
        bit  stopped;
        done_at  = -1;
        last_run = -100;
        stopped  = 1'b0;
        run_q.delete();
        runcyc_q.delete();
        fetch_q.delete();
        for (int i = 0; i < max_cyc; i++) begin
            step();
            bus.start    = 1'b0;
            bus.mem_data = pend_rd ? mem[pend_addr] : 16'hDEAD;
            pend_rd      = bus.mem_rd;
            pend_addr    = bus.mem_addr;
            if (bus.mem_rd) fetch_q.push_back(bus.mem_addr);
            if (bus.run) begin
                run_q.push_back(bus.instr);
                runcyc_q.push_back(cyc);
                done_at  = cyc + delay + 1;
                last_run = cyc;
            end
            bus.done = (cyc == done_at);
            if (stray && (bus.mem_rd || bus.run)) bus.done = 1'b1;
            if (stray && (cyc == last_run + 1)) begin
                bus.start      = 1'b1;
                bus.start_addr = 8'h40;
                bus.end_addr   = 8'h40;
            end
            if (stop_runs > 0 && run_q.size() == stop_runs && cyc == last_run + 1) begin
                stopped = 1'b1;
                break;
            end
            if (bus.halted) break;
        end
        bus.done  = 1'b0;
        bus.start = 1'b0;
        if (!stopped) begin
            checks++;
            if (bus.halted !== 1'b1) begin
                failures++;
                $display("FAIL run_halt: halted=%b required 1 within %0d cycles", bus.halted, max_cyc);
            end
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({bus.run, bus.mem_rd, bus.busy, bus.halted, bus.err} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags: run/mem_rd/busy/halted/err=%b required 00000",
                     {bus.run, bus.mem_rd, bus.busy, bus.halted, bus.err});
        end
        checks++;
        if ({bus.instr, bus.pc, bus.mem_addr} !== 32'h0) begin
            failures++;
            $display("FAIL reset_regs: instr=%h pc=%h mem_addr=%h required 0", bus.instr, bus.pc, bus.mem_addr);
        end
        step();
        rst = 1'b0;
        step();
        step();
        checks++;
        if (bus.busy !== 1'b0 || bus.halted !== 1'b0) begin
            failures++;
            $display("FAIL idle_no_start: busy=%b halted=%b required 0 0", bus.busy, bus.halted);
        end
    endtask

    task automatic test_program();
        mem[0] = 16'h1234; mem[1] = 16'h5678; mem[2] = 16'h9ABC;
        do_start(8'h00, 8'h02);
        run_prog(2, 1'b0, 0, 100);
        checks++;
        if (run_q.size() != 3) begin
            failures++; $display("FAIL prog_runs: count=%0d required 3", run_q.size());
        end
        checks++;
        if (run_q[0] !== 16'h1234) begin failures++; $display("FAIL prog_i0: instr=%h required 1234", run_q[0]); end
        checks++;
        if (run_q[1] !== 16'h5678) begin failures++; $display("FAIL prog_i1: instr=%h required 5678", run_q[1]); end
        checks++;
        if (run_q[2] !== 16'h9ABC) begin failures++; $display("FAIL prog_i2: instr=%h required 9abc", run_q[2]); end
        checks++;
        if (runcyc_q[0] - start_cyc != 3) begin
            failures++; $display("FAIL start_latency: got %0d required 3", runcyc_q[0] - start_cyc);
        end
        checks++;
        if (runcyc_q[1] - runcyc_q[0] != 6 || runcyc_q[2] - runcyc_q[1] != 6) begin
            failures++; $display("FAIL run_gap: got %0d,%0d required 6,6",
                                 runcyc_q[1] - runcyc_q[0], runcyc_q[2] - runcyc_q[1]);
        end
        checks++;
        if (bus.pc !== 8'h02 || bus.err !== 1'b0 || bus.busy !== 1'b0) begin
            failures++; $display("FAIL prog_end: pc=%h err=%b busy=%b required 02 0 0", bus.pc, bus.err, bus.busy);
        end
`ifdef BITTY_FETCH_PERF_EN
        checks++;
        if (bus.instr_count !== 16'd3 || bus.stall_cycles !== 16'd9) begin
            failures++; $display("FAIL prog_perf: instr_count=%0d stall=%0d required 3 9",
                                 bus.instr_count, bus.stall_cycles);
        end
`endif
        step(); step(); step();
        checks++;
        if (bus.halted !== 1'b1 || bus.instr !== 16'h9ABC || bus.pc !== 8'h02) begin
            failures++; $display("FAIL halt_hold: halted=%b instr=%h pc=%h required 1 9abc 02",
                                 bus.halted, bus.instr, bus.pc);
        end
    endtask

    task automatic test_single();
        mem[5] = 16'h00FF;
        do_start(8'h05, 8'h05);
        run_prog(2, 1'b0, 0, 50);
        checks++;
        if (run_q.size() != 1 || run_q[0] !== 16'h00FF) begin
            failures++; $display("FAIL single: runs=%0d instr=%h required 1 00ff", run_q.size(), run_q[0]);
        end
        checks++;
        if (bus.pc !== 8'h05) begin failures++; $display("FAIL single_pc: pc=%h required 05", bus.pc); end
    endtask

    task automatic test_wrap();
        mem[8'hFE] = 16'hA0FE; mem[8'hFF] = 16'hA0FF; mem[0] = 16'hA000; mem[1] = 16'hA001;
        do_start(8'hFE, 8'h01);
        run_prog(2, 1'b0, 0, 100);
        checks++;
        if (fetch_q.size() != 4 || fetch_q[0] !== 8'hFE || fetch_q[1] !== 8'hFF ||
            fetch_q[2] !== 8'h00 || fetch_q[3] !== 8'h01) begin
            failures++; $display("FAIL wrap_addrs: n=%0d %h %h %h %h required fe ff 00 01",
                                 fetch_q.size(), fetch_q[0], fetch_q[1], fetch_q[2], fetch_q[3]);
        end
        checks++;
        if (run_q[2] !== 16'hA000 || bus.pc !== 8'h01) begin
            failures++; $display("FAIL wrap_end: instr2=%h pc=%h required a000 01", run_q[2], bus.pc);
        end
    endtask

    task automatic test_done_vs_timeout();
        // done lands in the 4th EXEC cycle, exactly when the timeout would fire
        mem[8'h10] = 16'h1010; mem[8'h11] = 16'h1111;
        do_start(8'h10, 8'h11);
        run_prog(3, 1'b0, 0, 100);
        checks++;
        if (run_q.size() != 2 || bus.err !== 1'b0 || bus.pc !== 8'h11) begin
            failures++; $display("FAIL done_wins: runs=%0d err=%b pc=%h required 2 0 11",
                                 run_q.size(), bus.err, bus.pc);
        end
        checks++;
        if (runcyc_q[1] - runcyc_q[0] != 7) begin
            failures++; $display("FAIL done_wins_gap: got %0d required 7", runcyc_q[1] - runcyc_q[0]);
        end
    endtask

    task automatic test_timeout();
        mem[8'h20] = 16'h2020;
        do_start(8'h20, 8'h21);
        run_prog(1000, 1'b0, 0, 50);
        checks++;
        if (run_q.size() != 1 || bus.err !== 1'b1 || bus.pc !== 8'h20) begin
            failures++; $display("FAIL timeout: runs=%0d err=%b pc=%h required 1 1 20",
                                 run_q.size(), bus.err, bus.pc);
        end
        checks++;
        if (cyc - runcyc_q[0] != 5) begin
            failures++; $display("FAIL timeout_when: halt %0d cycles after run required 5", cyc - runcyc_q[0]);
        end
`ifdef BITTY_FETCH_PERF_EN
        checks++;
        if (bus.instr_count !== 16'd0 || bus.stall_cycles !== 16'd4) begin
            failures++; $display("FAIL timeout_perf: instr_count=%0d stall=%0d required 0 4",
                                 bus.instr_count, bus.stall_cycles);
        end
`endif
        step(); step();
        checks++;
        if (bus.err !== 1'b1) begin failures++; $display("FAIL err_sticky: err=%b required 1", bus.err); end
        do_start(8'h20, 8'h20);
        run_prog(2, 1'b0, 0, 50);
        checks++;
        if (bus.err !== 1'b0 || run_q.size() != 1 || run_q[0] !== 16'h2020) begin
            failures++; $display("FAIL restart: err=%b runs=%0d instr=%h required 0 1 2020",
                                 bus.err, run_q.size(), run_q[0]);
        end
    endtask

    task automatic test_stray();
        mem[8'h30] = 16'h3030; mem[8'h31] = 16'h3131; mem[8'h32] = 16'h3232;
        mem[8'h40] = 16'h4040;
        do_start(8'h30, 8'h32);
        run_prog(2, 1'b1, 0, 100);
        checks++;
        if (run_q.size() != 3 || run_q[0] !== 16'h3030 || run_q[1] !== 16'h3131 || run_q[2] !== 16'h3232) begin
            failures++; $display("FAIL stray_seq: n=%0d %h %h %h required 3030 3131 3232",
                                 run_q.size(), run_q[0], run_q[1], run_q[2]);
        end
        checks++;
        if (fetch_q.size() != 3 || fetch_q[2] !== 8'h32 || bus.pc !== 8'h32) begin
            failures++; $display("FAIL stray_addr: fetches=%0d last=%h pc=%h required 3 32 32",
                                 fetch_q.size(), fetch_q[2], bus.pc);
        end
    endtask

    task automatic test_mid_reset();
        mem[0] = 16'h1234; mem[1] = 16'h5678; mem[2] = 16'h9ABC;
        do_start(8'h00, 8'h02);
        run_prog(2, 1'b0, 2, 100);
        checks++;
        if (bus.busy !== 1'b1 || bus.pc !== 8'h01) begin
            failures++; $display("FAIL mid_pre: busy=%b pc=%h required 1 01", bus.busy, bus.pc);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.run, bus.mem_rd, bus.busy, bus.halted, bus.err} !== 5'b0 ||
            {bus.instr, bus.pc, bus.mem_addr} !== 32'h0) begin
            failures++; $display("FAIL mid_reset: flags=%b instr=%h pc=%h mem_addr=%h required all 0",
                                 {bus.run, bus.mem_rd, bus.busy, bus.halted, bus.err},
                                 bus.instr, bus.pc, bus.mem_addr);
        end
`ifdef BITTY_FETCH_PERF_EN
        checks++;
        if (bus.instr_count !== 16'd0 || bus.stall_cycles !== 16'd0) begin
            failures++; $display("FAIL mid_reset_perf: instr_count=%0d stall=%0d required 0 0",
                                 bus.instr_count, bus.stall_cycles);
        end
`endif
        pend_rd = 1'b0;
        step();
        rst = 1'b0;
        step(); step(); step();
        checks++;
        if (bus.busy !== 1'b0 || bus.halted !== 1'b0 || bus.run !== 1'b0) begin
            failures++; $display("FAIL mid_idle: busy=%b halted=%b run=%b required 0 0 0",
                                 bus.busy, bus.halted, bus.run);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start      = 1'b0;
        bus.start_addr = '0;
        bus.end_addr   = '0;
        bus.done       = 1'b0;
        bus.mem_data   = 16'hDEAD;
        pend_rd        = 1'b0;
        pend_addr      = '0;
        for (int i = 0; i < 256; i++) mem[i] = 16'hDEAD;
        test_reset();
        test_program();
        test_single();
        test_wrap();
        test_done_vs_timeout();
        test_timeout();
        test_stray();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
